// File: rtl/bldc_ramp_sequencer_if.sv
// bldc_ramp_sequencer_if
//   Command channel into the BLDC ramp sequencer.
//
//   Handshake: the master holds cmd_valid, cmd_dir and cmd_duty stable while
//   it offers a command. The command is taken on the rising sys_clk edge
//   where cmd_valid and cmd_ready are both high. cmd_ready does not depend on
//   cmd_valid.
//
//   Signals:
//     cmd_valid  master -> slave  command offered
//     cmd_ready  slave -> master  sequencer can take a command this cycle
//     cmd_dir    master -> slave  requested direction (0 none, 1 CW, 2 CCW)
//     cmd_duty   master -> slave  requested PWM duty
//
//   cmd_dir is a plain 2-bit vector here so this file stands on its own. The
//   sequencer casts it to its direction type.
interface bldc_ramp_sequencer_if #(
    parameter int duty_width = 11
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_dir;
    logic [duty_width-1:0] cmd_duty;

    modport master (
        output cmd_valid,
        output cmd_dir,
        output cmd_duty,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_dir,
        input  cmd_duty,
        output cmd_ready
    );
endinterface

// File: rtl/bldc_ramp_sequencer.sv
// bldc_ramp_sequencer
//   Soft-start / soft-stop sequencer for a BLDC driver. It takes direction
//   and duty commands and ramps the PWM duty toward the commanded target in
//   fixed steps. On a direction reversal or a stop request it ramps down,
//   then waits until the rotor reports zero speed before it starts again.
//   A driver fault, a hall error or a stop that never completes drops the
//   drive into a latched FAULT state.
//
//   Ports:
//     sys_clk        system clock
//     reset          asynchronous active-high reset
//     cmd            command channel (slave side of bldc_ramp_sequencer_if)
//     rpm            measured speed; only tested for zero
//     fault_n        driver fault, active low
//     hall_error     invalid hall code
//     clear_fault    single-cycle fault acknowledge
//     drive_enable   driver enable
//     drive_dir      driver direction
//     drive_duty     driver PWM duty
//     seq_state      current state encoding, for debug and checkers
//     fault_latched  high while in FAULT
//
//   All outputs are registered except cmd.cmd_ready, which decodes the
//   current state only.
package bldc_ramp_sequencer_pkg;
    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_CW   = 2'd1,
        DIR_CCW  = 2'd2
    } rotation_direction_t;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RAMP      = 3'd1,
        S_RUN       = 3'd2,
        S_RAMP_DOWN = 3'd3,
        S_WAIT_STOP = 3'd4,
        S_FAULT     = 3'd5
    } seq_state_t;
endpackage

module bldc_ramp_sequencer
    import bldc_ramp_sequencer_pkg::*;
#(
    parameter int clk_freq_hz   = 54_000_000,
    parameter int duty_width    = 11,
    parameter int counter_width = 32,
    parameter int step_period   = 5400,
    parameter int duty_step     = 8,
    parameter int max_duty      = 1000,
    parameter int stop_hold     = 54_000,
    parameter int stop_timeout  = 54_000_000
) (
    input  logic                     sys_clk,
    input  logic                     reset,
    bldc_ramp_sequencer_if.slave     cmd,
    input  logic [counter_width-1:0] rpm,
    input  logic                     fault_n,
    input  logic                     hall_error,
    input  logic                     clear_fault,
    output logic                     drive_enable,
    output rotation_direction_t      drive_dir,
    output logic [duty_width-1:0]    drive_duty,
    output logic [2:0]               seq_state,
    output logic                     fault_latched
);

    // One timer width serves the step, hold and timeout counters. It is
    // sized to count the longest of the stop timeout and one second of
    // clocks.
    localparam int TIMER_MAX = (stop_timeout > clk_freq_hz) ? stop_timeout : clk_freq_hz;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

    localparam logic [TIMER_W-1:0]    STEP_LAST = TIMER_W'(step_period - 1);
    localparam logic [TIMER_W-1:0]    HOLD_LAST = TIMER_W'(stop_hold - 1);
    localparam logic [TIMER_W-1:0]    WAIT_LAST = TIMER_W'(stop_timeout - 1);
    localparam logic [duty_width-1:0] DUTY_MAX  = duty_width'(max_duty);
    localparam logic [duty_width-1:0] DUTY_STEP = duty_width'(duty_step);

    seq_state_t             state_q, state_d;
    logic                   enable_d, fault_d;
    rotation_direction_t    dir_d;
    logic [duty_width-1:0]  duty_d;
    logic [duty_width-1:0]  target_q, target_d;
    rotation_direction_t    pend_dir_q, pend_dir_d;
    logic [duty_width-1:0]  pend_duty_q, pend_duty_d;
    logic [TIMER_W-1:0]     step_cnt_q, step_cnt_d;
    logic [TIMER_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic [TIMER_W-1:0]     wait_cnt_q, wait_cnt_d;

    logic                   cmd_ready_int;
    logic                   accept;
    logic                   step_tick;
    logic                   ext_fault;
    rotation_direction_t    cmd_dir_in;
    logic [duty_width-1:0]  duty_clamped;

    // Move one step toward goal and stop exactly on it. The guard on the
    // distance keeps the add from overflowing and the subtract from wrapping.
    function automatic logic [duty_width-1:0] step_toward(
        input logic [duty_width-1:0] cur,
        input logic [duty_width-1:0] goal
    );
        logic [duty_width-1:0] res;
        res = cur;
        if (cur < goal) begin
            res = ((goal - cur) > DUTY_STEP) ? (cur + DUTY_STEP) : goal;
        end else if (cur > goal) begin
            res = ((cur - goal) > DUTY_STEP) ? (cur - DUTY_STEP) : goal;
        end
        return res;
    endfunction

    assign cmd_ready_int = (state_q == S_IDLE) || (state_q == S_RAMP) || (state_q == S_RUN);
    assign cmd.cmd_ready = cmd_ready_int;
    assign accept        = cmd.cmd_valid && cmd_ready_int;
    // The unused code 3 is treated as a stop request, so it can never reach the driver.
    assign cmd_dir_in    = (cmd.cmd_dir == 2'd3) ? DIR_NONE : rotation_direction_t'(cmd.cmd_dir);
    assign duty_clamped  = (cmd.cmd_duty > DUTY_MAX) ? DUTY_MAX : cmd.cmd_duty;
    assign step_tick     = (step_cnt_q == STEP_LAST);
    assign ext_fault     = !fault_n || hall_error;
    assign seq_state     = state_q;

    always_comb begin
        state_d     = state_q;
        enable_d    = drive_enable;
        dir_d       = drive_dir;
        duty_d      = drive_duty;
        target_d    = target_q;
        pend_dir_d  = pend_dir_q;
        pend_duty_d = pend_duty_q;
        // Timers are zero unless the current state keeps them running. A
        // state entered fresh therefore always starts counting from zero.
        step_cnt_d  = '0;
        hold_cnt_d  = '0;
        wait_cnt_d  = '0;

        case (state_q)
            S_IDLE: begin
                if (accept && cmd_dir_in != DIR_NONE && duty_clamped != '0) begin
                    dir_d    = cmd_dir_in;
                    enable_d = 1'b1;
                    duty_d   = '0;
                    target_d = duty_clamped;
                    state_d  = S_RAMP;
                end
            end

            S_RAMP, S_RUN: begin
                if (accept) begin
                    // A command received here restarts the step timer.
                    if (cmd_dir_in != drive_dir || duty_clamped == '0) begin
                        pend_dir_d  = cmd_dir_in;
                        pend_duty_d = duty_clamped;
                        state_d     = S_RAMP_DOWN;
                    end else begin
                        target_d = duty_clamped;
                        state_d  = S_RAMP;
                    end
                end else if (state_q == S_RAMP) begin
                    if (drive_duty == target_q) begin
                        state_d = S_RUN;
                    end else if (step_tick) begin
                        duty_d = step_toward(drive_duty, target_q);
                        if (duty_d == target_q) begin
                            state_d = S_RUN;
                        end
                    end else begin
                        step_cnt_d = step_cnt_q + TIMER_W'(1);
                    end
                end
            end

            S_RAMP_DOWN: begin
                if (drive_duty == '0) begin
                    enable_d = 1'b0;
                    state_d  = S_WAIT_STOP;
                end else if (step_tick) begin
                    duty_d = step_toward(drive_duty, '0);
                    if (duty_d == '0) begin
                        enable_d = 1'b0;
                        state_d  = S_WAIT_STOP;
                    end
                end else begin
                    step_cnt_d = step_cnt_q + TIMER_W'(1);
                end
            end

            S_WAIT_STOP: begin
                enable_d   = 1'b0;
                duty_d     = '0;
                wait_cnt_d = wait_cnt_q + TIMER_W'(1);
                hold_cnt_d = (rpm == '0) ? (hold_cnt_q + TIMER_W'(1)) : '0;
                // A completed stop wins over a timeout that expires on the same clock.
                if (rpm == '0 && hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d  = '0;
                    wait_cnt_d  = '0;
                    pend_dir_d  = DIR_NONE;
                    pend_duty_d = '0;
                    if (pend_dir_q == DIR_NONE || pend_duty_q == '0) begin
                        dir_d   = DIR_NONE;
                        state_d = S_IDLE;
                    end else begin
                        dir_d    = pend_dir_q;
                        enable_d = 1'b1;
                        target_d = pend_duty_q;
                        state_d  = S_RAMP;
                    end
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_FAULT;
                end
            end

            S_FAULT: begin
                if (clear_fault && fault_n && !hall_error) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                enable_d = 1'b0;
                dir_d    = DIR_NONE;
                duty_d   = '0;
                state_d  = S_IDLE;
            end
        endcase

        // An external fault overrides any command taken on the same clock.
        if (ext_fault && state_q != S_IDLE && state_q != S_FAULT) begin
            state_d = S_FAULT;
        end

        // Keep the drive safe in FAULT. This covers entry from any path.
        if (state_d == S_FAULT) begin
            enable_d    = 1'b0;
            dir_d       = DIR_NONE;
            duty_d      = '0;
            target_d    = '0;
            pend_dir_d  = DIR_NONE;
            pend_duty_d = '0;
            step_cnt_d  = '0;
            hold_cnt_d  = '0;
            wait_cnt_d  = '0;
        end

        fault_d = (state_d == S_FAULT);
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            drive_enable  <= 1'b0;
            drive_dir     <= DIR_NONE;
            drive_duty    <= '0;
            fault_latched <= 1'b0;
            target_q      <= '0;
            pend_dir_q    <= DIR_NONE;
            pend_duty_q   <= '0;
            step_cnt_q    <= '0;
            hold_cnt_q    <= '0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            drive_enable  <= enable_d;
            drive_dir     <= dir_d;
            drive_duty    <= duty_d;
            fault_latched <= fault_d;
            target_q      <= target_d;
            pend_dir_q    <= pend_dir_d;
            pend_duty_q   <= pend_duty_d;
            step_cnt_q    <= step_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_bldc_ramp_sequencer.sv
// tb_bldc_ramp_sequencer
//   Directed bench for bldc_ramp_sequencer. It uses a small step period, step
//   size, duty clamp, hold count and timeout. A behavioural model tracks the
//   mode, the time spent in it and the duty. A compare process checks every
//   output against the model one time unit after each rising edge. The main
//   sequence also checks hand-computed values at known points.
module tb_bldc_ramp_sequencer;
    import bldc_ramp_sequencer_pkg::*;

    localparam int STEP    = 4;
    localparam int DSTEP   = 10;
    localparam int MAXD    = 100;
    localparam int HOLD    = 8;
    localparam int TIMEOUT = 200;

    // ---------------- clock / reset ----------------
    logic sys_clk = 1'b0;
    logic reset   = 1'b1;
    always #5 sys_clk = ~sys_clk;

    bldc_ramp_sequencer_if #(.duty_width(11)) cmd_bus ();

    logic [31:0]         rpm         = 32'd500;
    logic                fault_n     = 1'b1;
    logic                hall_error  = 1'b0;
    logic                clear_fault = 1'b0;
    logic                drive_enable;
    rotation_direction_t drive_dir;
    logic [10:0]         drive_duty;
    logic [2:0]          seq_state;
    logic                fault_latched;

    bldc_ramp_sequencer #(
        .duty_width   (11),
        .counter_width(32),
        .step_period  (STEP),
        .duty_step    (DSTEP),
        .max_duty     (MAXD),
        .stop_hold    (HOLD),
        .stop_timeout (TIMEOUT)
    ) dut (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .cmd          (cmd_bus.slave),
        .rpm          (rpm),
        .fault_n      (fault_n),
        .hall_error   (hall_error),
        .clear_fault  (clear_fault),
        .drive_enable (drive_enable),
        .drive_dir    (drive_dir),
        .drive_duty   (drive_duty),
        .seq_state    (seq_state),
        .fault_latched(fault_latched)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Modes: 0 idle, 1 ramp, 2 run, 3 ramp down, 4 wait stop, 5 fault.
    // m_age counts clocks since the mode was entered. A ramp step falls on
    // every STEP-th clock of that count.
    int m_mode = 0, m_en = 0, m_dir = 0, m_duty = 0, m_target = 0;
    int m_pdir = 0, m_pduty = 0, m_age = 0, m_zero = 0;

    task automatic enter(input int mode);
        m_mode = mode;
        m_age  = 0;
        m_zero = 0;
    endtask

    task automatic enter_fault();
        enter(5);
        m_en = 0; m_dir = 0; m_duty = 0; m_target = 0; m_pdir = 0; m_pduty = 0;
    endtask

    task automatic model_step();
        int acc, cd, cdir;
        if (reset) begin
            enter(0);
            m_en = 0; m_dir = 0; m_duty = 0; m_target = 0; m_pdir = 0; m_pduty = 0;
            return;
        end
        acc  = (cmd_bus.cmd_valid && m_mode <= 2) ? 1 : 0;
        cd   = (int'(cmd_bus.cmd_duty) > MAXD) ? MAXD : int'(cmd_bus.cmd_duty);
        cdir = int'(cmd_bus.cmd_dir);
        if (m_mode != 0 && m_mode != 5 && (!fault_n || hall_error)) begin
            enter_fault();
            return;
        end
        m_age++;
        case (m_mode)
            0: if (acc != 0 && cdir != 0 && cd > 0) begin
                m_dir = cdir; m_en = 1; m_duty = 0; m_target = cd;
                enter(1);
            end
            1, 2: begin
                if (acc != 0) begin
                    if (cdir != m_dir || cd == 0) begin
                        m_pdir = cdir; m_pduty = cd;
                        enter(3);
                    end else begin
                        m_target = cd;
                        enter(1);
                    end
                end else if (m_mode == 1) begin
                    if (m_duty == m_target) enter(2);
                    else if (m_age % STEP == 0) begin
                        if (m_duty < m_target)
                            m_duty = (m_duty + DSTEP > m_target) ? m_target : m_duty + DSTEP;
                        else
                            m_duty = (m_duty - DSTEP < m_target) ? m_target : m_duty - DSTEP;
                        if (m_duty == m_target) enter(2);
                    end
                end
            end
            3: begin
                if (m_duty == 0) begin
                    m_en = 0; enter(4);
                end else if (m_age % STEP == 0) begin
                    m_duty = (m_duty - DSTEP < 0) ? 0 : m_duty - DSTEP;
                    if (m_duty == 0) begin
                        m_en = 0; enter(4);
                    end
                end
            end
            4: begin
                m_zero = (rpm == 0) ? m_zero + 1 : 0;
                if (m_zero == HOLD) begin
                    if (m_pdir == 0 || m_pduty == 0) begin
                        m_dir = 0;
                        enter(0);
                    end else begin
                        m_dir = m_pdir; m_en = 1; m_target = m_pduty;
                        enter(1);
                    end
                    m_pdir = 0; m_pduty = 0;
                end else if (m_age == TIMEOUT) begin
                    enter_fault();
                end
            end
            5: if (clear_fault && fault_n && !hall_error) enter(0);
            default: enter(0);
        endcase
    endtask

    // ---------------- compare process ----------------
    always @(posedge sys_clk) begin
        model_step();
        #1;
        check("model_state",    int'(seq_state),         m_mode);
        check("model_enable",   int'(drive_enable),      m_en);
        check("model_dir",      int'(drive_dir),         m_dir);
        check("model_duty",     int'(drive_duty),        m_duty);
        check("model_ready",    int'(cmd_bus.cmd_ready), (m_mode <= 2) ? 1 : 0);
        check("model_fault",    int'(fault_latched),     (m_mode == 5) ? 1 : 0);
        check("duty_le_max",    (int'(drive_duty) <= MAXD) ? 1 : 0, 1);
        check("off_means_zero", (!drive_enable && drive_duty != 0) ? 1 : 0, 0);
    end

    // ---------------- driver tasks ----------------
    // Called at a falling edge. The command is offered for one clock.
    task automatic send_cmd(input int dir, input int duty);
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_dir   = 2'(dir);
        cmd_bus.cmd_duty  = 11'(duty);
        @(negedge sys_clk);
        cmd_bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_clocks(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic pulse_clear();
        clear_fault = 1'b1;
        @(negedge sys_clk);
        clear_fault = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_dir   = 2'd0;
        cmd_bus.cmd_duty  = 11'd0;
        wait_clocks(3);
        reset = 1'b0;

        check("rst_state",  int'(seq_state), 0);
        check("rst_enable", int'(drive_enable), 0);
        check("rst_duty",   int'(drive_duty), 0);
        check("rst_dir",    int'(drive_dir), 0);
        check("rst_fault",  int'(fault_latched), 0);
        check("rst_ready",  int'(cmd_bus.cmd_ready), 1);

        // Start CW at 35: 10, 20, 30, then 35 with RUN.
        send_cmd(1, 35);
        check("a_ramp", int'(seq_state), 1);
        check("a_en",   int'(drive_enable), 1);
        wait_clocks(4); check("a_d10", int'(drive_duty), 10);
        wait_clocks(4); check("a_d20", int'(drive_duty), 20);
        wait_clocks(4); check("a_d30", int'(drive_duty), 30);
        check("a_still_ramp", int'(seq_state), 1);
        wait_clocks(4); check("a_d35", int'(drive_duty), 35);
        check("a_run", int'(seq_state), 2);

        // Reverse to CCW 50: down 25, 15, 5, 0, wait for zero speed, then up.
        send_cmd(2, 50);
        check("b_down", int'(seq_state), 3);
        wait_clocks(16);
        check("b_wait", int'(seq_state), 4);
        check("b_en0",  int'(drive_enable), 0);
        rpm = 32'd0;
        wait_clocks(7); check("b_hold7", int'(seq_state), 4);
        wait_clocks(1); check("b_ramp", int'(seq_state), 1);
        check("b_ccw", int'(drive_dir), 2);
        rpm = 32'd300;
        wait_clocks(20);
        check("b_d50", int'(drive_duty), 50);
        check("b_run", int'(seq_state), 2);

        // Command 500 is clamped to 100.
        send_cmd(2, 500);
        wait_clocks(20);
        check("c_d100", int'(drive_duty), 100);
        check("c_run",  int'(seq_state), 2);

        // A fault in the same cycle as a command wins.
        send_cmd(2, 20);
        fault_n = 1'b0;
        send_cmd(1, 30);
        check("d_fault",  int'(seq_state), 5);
        check("d_en",     int'(drive_enable), 0);
        check("d_duty",   int'(drive_duty), 0);
        check("d_dir",    int'(drive_dir), 0);
        check("d_latch",  int'(fault_latched), 1);
        check("d_ready",  int'(cmd_bus.cmd_ready), 0);
        pulse_clear();
        check("d_ignored", int'(seq_state), 5);
        fault_n = 1'b1;
        wait_clocks(1);
        pulse_clear();
        check("d_idle", int'(seq_state), 0);

        // Stop timeout while rpm never settles; interrupted zero runs reset the hold count.
        rpm = 32'd120;
        send_cmd(1, 20);
        wait_clocks(8);
        check("e_run20", int'(drive_duty), 20);
        send_cmd(0, 0);
        wait_clocks(8);
        check("e_wait", int'(seq_state), 4);
        rpm = 32'd0;   wait_clocks(5);
        rpm = 32'd120; wait_clocks(1);
        rpm = 32'd0;   wait_clocks(7);
        rpm = 32'd120;
        check("e_hold_reset", int'(seq_state), 4);
        wait_clocks(186);
        check("e_w199", int'(seq_state), 4);
        wait_clocks(1);
        check("e_timeout", int'(seq_state), 5);
        pulse_clear();
        check("e_idle", int'(seq_state), 0);

        // Commands without a direction or with zero duty are ignored in idle.
        // A stop request ends in idle.
        send_cmd(1, 0);  check("f_zero_ign", int'(seq_state), 0);
        send_cmd(0, 50); check("f_none_ign", int'(seq_state), 0);
        send_cmd(1, 10);
        wait_clocks(4);
        check("f_run10", int'(seq_state), 2);
        rpm = 32'd0;
        send_cmd(0, 5);
        wait_clocks(4);
        check("f_wait", int'(seq_state), 4);
        wait_clocks(8);
        check("f_idle", int'(seq_state), 0);
        check("f_dir0", int'(drive_dir), 0);

        // A hall error during a ramp faults the drive.
        send_cmd(1, 30);
        wait_clocks(2);
        hall_error = 1'b1;
        wait_clocks(1);
        hall_error = 1'b0;
        check("g_hall_fault", int'(seq_state), 5);
        pulse_clear();
        check("g_idle", int'(seq_state), 0);

        // Reset asserted during a ramp down.
        rpm = 32'd300;
        send_cmd(1, 60);
        wait_clocks(24);
        check("h_run60", int'(drive_duty), 60);
        send_cmd(2, 10);
        wait_clocks(5);
        check("h_down", int'(seq_state), 3);
        check("h_d50",  int'(drive_duty), 50);
        #2;
        reset = 1'b1;
        #1;
        check("h_state", int'(seq_state), 0);
        check("h_en",    int'(drive_enable), 0);
        check("h_duty",  int'(drive_duty), 0);
        check("h_dir",   int'(drive_dir), 0);
        check("h_fault", int'(fault_latched), 0);
        wait_clocks(2);
        reset = 1'b0;
        wait_clocks(1);
        check("h_ready", int'(cmd_bus.cmd_ready), 1);
        check("h_idle",  int'(seq_state), 0);

        wait_clocks(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
